// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - shared size encodings, state enum and access helpers for lsu_unit
package npc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Byte-strobe pattern for the access size before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts the addressed field from a read doubleword and extends it
module lsu_load_align
  import npc_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] field;

  assign field = rdata >> {off, 3'b000};

  always_comb begin
    result = field;
    case (size)
      SZ_B: result = is_unsigned ? {{(XLEN-8){1'b0}}, field[7:0]}
                                 : {{(XLEN-8){field[7]}}, field[7:0]};
      SZ_H: result = is_unsigned ? {{(XLEN-16){1'b0}}, field[15:0]}
                                 : {{(XLEN-16){field[15]}}, field[15:0]};
      SZ_W: result = is_unsigned ? {{(XLEN-32){1'b0}}, field[31:0]}
                                 : {{(XLEN-32){field[31]}}, field[31:0]};
      default: result = field;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit: one aligned req/gnt/rvalid access per op, extended writeback
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_unit
  import npc_lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_is_store,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [4:0]      ex_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            wb_misalign,
  output logic            wb_buserr
);

  lsu_state_t state, state_nxt;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            store_q;
  logic [4:0]      rd_q;

  logic [XLEN-1:0] wb_data_q;
  logic            wb_we_q;
  logic            misalign_q;
  logic            buserr_q;

  logic [2:0]      off;
  logic [XLEN-1:0] load_result;
  logic            accept_misal;
  logic            busy;
  logic            timeout_hit;

  assign off          = addr_q[2:0];
  assign accept_misal = is_misaligned(ex_size, ex_addr[2:0]);
  assign busy         = (state == REQ) || (state == WAIT);

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (mem_rdata),
    .off         (off),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_result)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] to_cnt;

  // Counter restarts on every state change so REQ and WAIT each get a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != state_nxt) begin
      to_cnt <= '0;
    end else if (busy) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = busy && (to_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and read data take priority over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          state_nxt = accept_misal ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt = store_q ? RESP : WAIT;
        end else if (timeout_hit) begin
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (mem_rvalid || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            addr_q     <= ex_addr;
            wdata_q    <= ex_wdata;
            size_q     <= ex_size;
            uns_q      <= ex_unsigned;
            store_q    <= ex_is_store;
            rd_q       <= ex_rd;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
            misalign_q <= accept_misal;
            buserr_q   <= 1'b0;
          end
        end
        REQ: begin
          if (!mem_gnt && timeout_hit) begin
            buserr_q <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_data_q <= load_result;
            wb_we_q   <= 1'b1;
          end else if (timeout_hit) begin
            buserr_q <= 1'b1;
          end
        end
        RESP: begin
          if (wb_ready) begin
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wdata = mem_req ? (wdata_q << {off, 3'b000}) : '0;
  assign mem_wmask = mem_req ? (size_mask(size_q) << off) : 8'h00;

  assign wb_valid    = (state == RESP);
  assign wb_data     = wb_data_q;
  assign wb_rd       = rd_q;
  assign wb_we       = wb_we_q;
  assign wb_misalign = misalign_q;
  assign wb_buserr   = buserr_q;

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - scoreboard bench for lsu_unit with scripted bus and writeback responders
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_store, ex_unsigned;
  logic [63:0] ex_addr, ex_wdata;
  logic [1:0]  ex_size;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_ready, wb_we, wb_misalign, wb_buserr;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        berr;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lsu_unit #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_is_store(ex_is_store), .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_misalign(wb_misalign), .wb_buserr(wb_buserr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    int nb;
    m  = '0;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] o;
    o = '0;
    for (int j = 0; j < 8; j++)
      if (j >= int'(off)) o[j*8 +: 8] = wd[(j - int'(off))*8 +: 8];
    return o;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rd, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    logic [7:0]  fill;
    int nb;
    v  = '0;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) v[i*8 +: 8] = rd[(int'(off) + i)*8 +: 8];
    fill = (!uns && v[nb*8 - 1]) ? 8'hFF : 8'h00;
    for (int i = nb; i < 8; i++) v[i*8 +: 8] = fill;
    return v;
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [2:0] off);
    int nb;
    nb = 1 << sz;
    return (int'(off) % nb) != 0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_ex_ready"}, ex_ready, 1);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wmask"}, mem_wmask, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
    check({tag, "_wb_we"}, wb_we, 0);
    check({tag, "_wb_misalign"}, wb_misalign, 0);
    check({tag, "_wb_buserr"}, wb_buserr, 0);
  endtask

  task automatic check_req(input logic [63:0] addr, input logic [63:0] wd,
                           input logic st, input logic [1:0] sz);
    check("req_mem_req", mem_req, 1);
    check("req_mem_we", mem_we, st);
    check("req_mem_addr", mem_addr, {addr[63:3], 3'b000});
    check("req_mem_wmask", mem_wmask, exp_mask(sz, addr[2:0]));
    if (st) check("req_mem_wdata", mem_wdata, exp_wdata(wd, addr[2:0]));
    check("req_ex_ready", ex_ready, 0);
  endtask

  task automatic check_wb(input logic do_pop);
    wb_exp_t e;
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb[0];
      check("wb_valid", wb_valid, 1);
      check("wb_data", wb_data, e.data);
      check("wb_rd", wb_rd, e.rd);
      check("wb_we", wb_we, e.we);
      check("wb_misalign", wb_misalign, e.mis);
      check("wb_buserr", wb_buserr, e.berr);
      check("resp_ex_ready", ex_ready, 0);
      if (do_pop) void'(sb.pop_front());
    end
  endtask

  task automatic drain_resp(input int rdy_dly);
    for (int i = 0; i < rdy_dly; i++) begin
      check_wb(1'b0);
      tick();
    end
    wb_ready = 1'b1;
    check_wb(1'b1);
    tick();
    wb_ready = 1'b0;
    check("post_ex_ready", ex_ready, 1);
    check("post_wb_valid", wb_valid, 0);
    check("post_wb_misalign", wb_misalign, 0);
  endtask

  task automatic run_op(input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdata,
                        input logic st, input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                        input int gnt_dly, input int rdy_dly, input logic stray);
    wb_exp_t e;
    logic mis;
    mis = exp_mis(sz, addr[2:0]);
    ex_addr = addr; ex_wdata = wd; ex_is_store = st; ex_size = sz; ex_unsigned = uns; ex_rd = rd;
    ex_valid = 1'b1;
    check("idle_ex_ready", ex_ready, 1);
    tick();
    ex_valid = 1'b0;
    e.rd   = rd;
    e.mis  = mis;
    e.berr = 1'b0;
    e.we   = !st && !mis;
    e.data = (st || mis) ? 64'h0 : exp_load(rdata, addr[2:0], sz, uns);
    sb.push_back(e);
    if (mis) begin
      check("misal_no_req", mem_req, 0);
    end else begin
      for (int i = 0; i < gnt_dly; i++) begin
        mem_rvalid = stray;
        mem_rdata  = ~rdata;
        check_req(addr, wd, st, sz);
        tick();
      end
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b1;
      check_req(addr, wd, st, sz);
      tick();
      mem_gnt = 1'b0;
      check("req_drop", mem_req, 0);
      if (!st) begin
        check("wait_no_wb", wb_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
    drain_resp(rdy_dly);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra, rw, rr;
    logic [1:0]  rs;
    logic [2:0]  ro;
    rst = 1'b1;
    ex_valid = 0; ex_addr = '0; ex_wdata = '0; ex_is_store = 0; ex_size = 0; ex_unsigned = 0; ex_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; wb_ready = 0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    run_op(64'h8000_0003, 64'h0, 64'h0000_0000_F000_0000, 0, 2'b00, 0, 5'd3, 0, 0, 0);
    run_op(64'h8000_0003, 64'h0, 64'h0000_0000_F000_0000, 0, 2'b00, 1, 5'd4, 0, 0, 0);
    run_op(64'h8000_0006, 64'h1234, 64'h0, 1, 2'b01, 0, 5'd5, 0, 0, 0);
    run_op(64'h8000_0002, 64'h0, 64'h0, 0, 2'b10, 0, 5'd6, 0, 0, 0);
    run_op(64'h8000_0010, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 2'b11, 1, 5'd7, 5, 3, 1);
    run_op(64'h8000_0024, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 2'b10, 0, 5'd8, 5, 3, 0);
    run_op(64'h8000_0004, 64'h0, 64'h0, 1, 2'b11, 0, 5'd9, 0, 1, 0);
    run_op(64'h8000_0005, 64'h0, 64'h0, 0, 2'b01, 0, 5'd10, 0, 0, 0);
    run_op(64'h8000_0004, 64'h0, 64'h0000_8000_0000_0000, 0, 2'b01, 0, 5'd11, 0, 0, 0);

    for (int k = 0; k < 10; k++) begin
      rs = 2'($urandom_range(0, 3));
      ro = 3'($urandom_range(0, 7));
      ro = ro & ~3'((1 << rs) - 1);
      ra = {$urandom, $urandom};
      ra[2:0] = ro;
      rw = {$urandom, $urandom};
      rr = {$urandom, $urandom};
      run_op(ra, rw, rr, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end

    // Reset while a load waits for read data; the late rvalid must be ignored.
    ex_addr = 64'h8000_0040; ex_size = 2'b11; ex_is_store = 0; ex_rd = 5'd17; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("wait_mem_req", mem_req, 0);
    check("wait_ex_ready", ex_ready, 0);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("after_rst");
      tick();
    end

`ifdef LSU_TIMEOUT_EN
    ex_addr = 64'h8000_0080; ex_size = 2'b10; ex_is_store = 0; ex_rd = 5'd21; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req", mem_req, 1);
      check("to_wb_valid", wb_valid, 0);
      tick();
    end
    sb.push_back('{data: 64'h0, rd: 5'd21, we: 1'b0, mis: 1'b0, berr: 1'b1});
    check("to_req_drop", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    drain_resp(1);
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store stage directly downstream of the execute ALU in the npc core.
- Consumes the ALU result as the effective address and rs2 as store data.
- Performs one aligned memory access per instruction over a req/gnt/rvalid bus.
- Returns sign/zero-extended load data to writeback through a valid/ready handshake.

Parameters:
- XLEN, 64, data/address width. Only 64 is supported.
- TIMEOUT, 255, max cycles in REQ or WAIT before bus error. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  execute stage offers a memory op
- ex_ready  out  1  lsu can accept
- ex_addr  in  XLEN  effective address (ALU result)
- ex_wdata  in  XLEN  store data (rs2)
- ex_is_store  in  1  1 = store, 0 = load
- ex_size  in  2  00 B, 01 H, 10 W, 11 D
- ex_unsigned  in  1  zero-extend the load
- ex_rd  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  address, doubleword-aligned ({ex_addr[63:3],3'b0})
- mem_wdata  out  XLEN  store data shifted into its byte lane
- mem_wmask  out  8  byte strobes
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data, full doubleword
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  XLEN  extended load data; 0 for stores
- wb_rd  out  5  latched rd
- wb_we  out  1  1 only for a successful load
- wb_misalign  out  1  address misaligned, no bus access made
- wb_buserr  out  1  timeout; constant 0 without LSU_TIMEOUT_EN

Behaviour:
- Reset (asynchronous): state IDLE. All outputs and latched fields are 0, except ex_ready, which is 1.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ex_ready=1.
  - On ex_valid, latch addr, wdata, size, unsigned, is_store and rd.
  - If misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0), go to RESP with wb_misalign=1, wb_we=0, wb_data=0. No mem_req is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wmask are held stable until mem_gnt.
  - Byte offset off=addr[2:0].
  - Masks before shifting: B 0x01, H 0x03, W 0x0F, D 0xFF. mem_wmask = that mask << off.
  - mem_wdata = wdata << (off*8).
  - For loads, mem_wmask still carries the access mask and mem_we=0.
  - On mem_gnt: a store goes to RESP; a load goes to WAIT.
  - mem_req drops the cycle after gnt.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - On mem_rvalid, extract field = mem_rdata >> (off*8), truncated to the size.
  - Sign-extend, or zero-extend if unsigned, then register into wb_data with wb_we=1 and go to RESP.
  - D ignores unsigned.
- RESP:
  - wb_valid=1. wb_* outputs are stable until wb_ready.
  - On wb_ready, go to IDLE and clear wb_misalign/wb_buserr.
  - No new op is accepted in the same cycle (ex_ready=0 outside IDLE).
- Latency from the accept edge T:
  - mem_req is visible in T+1.
  - With gnt at T+1: a store shows wb_valid in T+2.
  - A load with rvalid at T+2 shows wb_valid in T+3.
  - A misaligned op shows wb_valid in T+1.
- Reset mid-operation: return to IDLE immediately. mem_req and wb_valid drop. An in-flight rvalid after reset is ignored.
- One outstanding transaction only.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entering REQ or WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT, go to RESP with wb_buserr=1, wb_we=0, wb_data=0, and deassert mem_req.
  - A later stray rvalid is ignored.
- Undefined: no counter; the lsu waits indefinitely; wb_buserr is tied to 0.

Decomposition:
- Package npc_lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - the state enum (IDLE, REQ, WAIT, RESP)
  - the base-mask function size→8-bit mask
  - the misalign-check function
- Sub-module lsu_load_align (combinational): mem_rdata, off, size, unsigned → extended XLEN result.
- Shift/mask generation stays inline.

Test Plan:
- Load byte, addr 0x8000_0003, rdata 0x0000_0000_F000_0000, signed, gnt T+1, rvalid T+2 → mem_addr 0x8000_0000, wmask 0x08; wb_valid T+3, wb_data 0xFFFF_FFFF_FFFF_FFF0, wb_we=1.
- Same load with ex_unsigned=1 → wb_data 0x0000_0000_0000_00F0.
- Store half, addr 0x8000_0006, wdata 0x1234 → mem_we=1, wmask 0xC0, mem_wdata 0x1234_0000_0000_0000; wb_valid T+2, wb_we=0.
- Load word, addr 0x8000_0002 → no mem_req ever; wb_valid T+1, wb_misalign=1, wb_data 0.
- Gnt delayed 5 cycles and wb_ready held low 3 cycles → mem_* stable throughout REQ, wb_* stable throughout RESP, ex_ready=0 until return to IDLE.
- rst asserted in WAIT, then rvalid pulsed → all outputs 0 except ex_ready=1, no wb_valid; with LSU_TIMEOUT_EN and TIMEOUT=4, withhold gnt → wb_buserr=1 after 4 cycles in REQ.
